// File: rtl/frame_deframer.sv
// Receive-side byte deframer: hunts for SYNC_BYTE, reads LEN, forwards LEN payload bytes with last_o.
// Define FRAME_CHK_EN to expect and verify a trailing XOR checksum byte after the payload.
module frame_deframer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16
) (
  input  logic       pclk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o,
  input  logic       ready_i,
  output logic       frame_done_o,
  output logic       err_o
);

`ifdef FRAME_CHK_EN
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       accept, len_bad, cnt_one;
  logic       len_load, pay_load, err_d, done_d;
`ifdef FRAME_CHK_EN
  logic [7:0] xor_q;
`endif

  // Only the payload path is throttled; framing bytes are always consumed.
  assign ready_o = (state_q == S_PAY) ? (!valid_o || ready_i) : 1'b1;
  assign accept  = valid_i && ready_o;
  assign len_bad = (data_i == 8'd0) || (int'(data_i) > MAX_LEN);
  assign cnt_one = (cnt_q == 8'd1);

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: if (accept && data_i == SYNC_BYTE) state_d = S_LEN;
      S_LEN:  if (accept) state_d = len_bad ? S_HUNT : S_PAY;
`ifdef FRAME_CHK_EN
      S_PAY:  if (accept && cnt_one) state_d = S_CHK;
      S_CHK:  if (accept) state_d = S_HUNT;
`else
      S_PAY:  if (accept && cnt_one) state_d = S_HUNT;
`endif
      default: state_d = S_HUNT;
    endcase
  end

  always_comb begin
    len_load = 1'b0;
    pay_load = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_LEN: if (accept) begin
        if (len_bad) err_d    = 1'b1;
        else         len_load = 1'b1;
      end
      S_PAY: if (accept) begin
        pay_load = 1'b1;
`ifndef FRAME_CHK_EN
        done_d   = cnt_one;
`endif
      end
`ifdef FRAME_CHK_EN
      S_CHK: if (accept) begin
        if (data_i == xor_q) done_d = 1'b1;
        else                 err_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (len_load) begin
      cnt_q <= data_i;
    end else if (pay_load) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

`ifdef FRAME_CHK_EN
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i)         xor_q <= 8'd0;
    else if (len_load) xor_q <= 8'd0;
    else if (pay_load) xor_q <= xor_q ^ data_i;
  end
`endif

  // Output register: a new byte may load in the same cycle the held one drains.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o  <= 8'd0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (pay_load) begin
      data_o  <= data_i;
      valid_o <= 1'b1;
      last_o  <= cnt_one;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      frame_done_o <= done_d;
      err_o        <= err_d;
    end
  end

endmodule
